player_bullet: RTL and testbench

- Player projectile: launches from the player ship on a fire press, climbs one step per frame, and tests overlap against one enemy bounding box every cycle.
- It is the source end of the enemy's hit_i interface: it consumes the enemy's position and dead outputs, and on overlap it pulses hit_o into that enemy's hit_i.
- It also supplies its own rectangle and colour to the VGA pixel mux.
- Screen is 640x480; y grows downward.

---
 rtl/player_bullet.sv | 161 ++++++++++++++++
 tb/tb_player_bullet.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/player_bullet.sv
// Player projectile: launch on fire edge, climb per frame, enemy overlap -> hit pulse.
// Optional PLAYER_BULLET_COOLDOWN_EN adds a frame-counted refire lockout.
module player_bullet #(
`ifdef PLAYER_BULLET_COOLDOWN_EN
   parameter logic [7:0]  cooldown_frames_p = 8'd15,
`endif
   parameter logic [11:0] color_p           = {4'hF, 4'h0, 4'h0},
   parameter logic [9:0]  bullet_width_p    = 10'd2,
   parameter logic [9:0]  bullet_height_p   = 10'd8,
   parameter logic [9:0]  step_p            = 10'd4,
   parameter logic [9:0]  player_width_p    = 10'd40
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       frame_i,
   input  logic       fire_i,
   input  logic [9:0] player_left_i,
   input  logic [9:0] player_top_i,
   input  logic [9:0] enemy_left_i,
   input  logic [9:0] enemy_right_i,
   input  logic [9:0] enemy_top_i,
   input  logic [9:0] enemy_bot_i,
   input  logic       enemy_dead_i,
   output logic       hit_o,
   output logic       active_o,
   output logic [9:0] left_pos_o,
   output logic [9:0] right_pos_o,
   output logic [9:0] top_pos_o,
   output logic [9:0] bot_pos_o,
   output logic [3:0] bullet_red_o,
   output logic [3:0] bullet_green_o,
   output logic [3:0] bullet_blue_o
);

   localparam logic [9:0] center_off_lp = (player_width_p - bullet_width_p) >> 1;
   localparam logic [9:0] max_left_lp   = 10'd640 - bullet_width_p;

`ifdef PLAYER_BULLET_COOLDOWN_EN
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_FLY  = 4'b0010,
      ST_HIT  = 4'b0100,
      ST_COOL = 4'b1000
   } state_t;
   localparam state_t end_st_lp = ST_COOL;
`else
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_FLY  = 4'b0010,
      ST_HIT  = 4'b0100
   } state_t;
   localparam state_t end_st_lp = ST_IDLE;
`endif

   state_t      state_q, state_d;
   logic [9:0]  left_q, left_d;
   logic [9:0]  top_q, top_d;
   logic        fire_q, fire_d;
   logic        hit_q, hit_d;
   logic        active_q, active_d;
`ifdef PLAYER_BULLET_COOLDOWN_EN
   logic [7:0]  cnt_q, cnt_d;
`endif

   logic        fire_rise;
   logic        overlap;
   logic [9:0]  right_w;
   logic [9:0]  bot_w;
   logic [10:0] launch_sum;

   assign right_w    = left_q + bullet_width_p - 10'd1;
   assign bot_w      = top_q + bullet_height_p - 10'd1;
   assign fire_rise  = fire_i & ~fire_q;
   assign launch_sum = {1'b0, player_left_i} + {1'b0, center_off_lp};

   assign overlap = (left_q <= enemy_right_i) & (right_w >= enemy_left_i) &
                    (top_q <= enemy_bot_i) & (bot_w >= enemy_top_i) &
                    ~enemy_dead_i;

   always_comb begin
      state_d = state_q;
      left_d  = left_q;
      top_d   = top_q;
      fire_d  = fire_i;
`ifdef PLAYER_BULLET_COOLDOWN_EN
      cnt_d   = 8'd0;
`endif
      unique case (1'b1)
         state_q[0]: begin
            if (fire_rise && (player_top_i >= bullet_height_p)) begin
               state_d = ST_FLY;
               top_d   = player_top_i - bullet_height_p;
               if (launch_sum > {1'b0, max_left_lp})
                  left_d = max_left_lp;
               else
                  left_d = launch_sum[9:0];
            end
         end
         state_q[1]: begin
            if (overlap)
               state_d = ST_HIT;
            else if (frame_i && (top_q < step_p))
               state_d = end_st_lp;
            else if (frame_i)
               top_d = top_q - step_p;
         end
         state_q[2]: begin
            state_d = end_st_lp;
         end
`ifdef PLAYER_BULLET_COOLDOWN_EN
         state_q[3]: begin
            cnt_d = cnt_q;
            if (frame_i) begin
               if (cnt_q == cooldown_frames_p - 8'd1)
                  state_d = ST_IDLE;
               else
                  cnt_d = cnt_q + 8'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
      active_d = (state_d == ST_FLY);
      hit_d    = (state_d == ST_HIT);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         left_q   <= 10'd0;
         top_q    <= 10'd0;
         fire_q   <= 1'b1;
         hit_q    <= 1'b0;
         active_q <= 1'b0;
`ifdef PLAYER_BULLET_COOLDOWN_EN
         cnt_q    <= 8'd0;
`endif
      end else begin
         state_q  <= state_d;
         left_q   <= left_d;
         top_q    <= top_d;
         fire_q   <= fire_d;
         hit_q    <= hit_d;
         active_q <= active_d;
`ifdef PLAYER_BULLET_COOLDOWN_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign hit_o          = hit_q;
   assign active_o       = active_q;
   assign left_pos_o     = left_q;
   assign right_pos_o    = right_w;
   assign top_pos_o      = top_q;
   assign bot_pos_o      = bot_w;
   assign bullet_red_o   = color_p[11:8];
   assign bullet_green_o = color_p[7:4];
   assign bullet_blue_o  = color_p[3:0];

endmodule

// File: tb/tb_player_bullet.sv
// Directed bench for player_bullet: launch, miss, hit, held fire, reset, refire.
// Build with PLAYER_BULLET_COOLDOWN_EN to exercise the cooldown lockout path.
module tb_player_bullet;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       frame_i = 1'b0;
   logic       fire_i = 1'b0;
   logic [9:0] player_left_i = 10'd0;
   logic [9:0] player_top_i = 10'd0;
   logic [9:0] enemy_left_i = 10'd0;
   logic [9:0] enemy_right_i = 10'd0;
   logic [9:0] enemy_top_i = 10'd0;
   logic [9:0] enemy_bot_i = 10'd0;
   logic       enemy_dead_i = 1'b1;
   logic       hit_o;
   logic       active_o;
   logic [9:0] left_pos_o;
   logic [9:0] right_pos_o;
   logic [9:0] top_pos_o;
   logic [9:0] bot_pos_o;
   logic [3:0] bullet_red_o;
   logic [3:0] bullet_green_o;
   logic [3:0] bullet_blue_o;

   int n_cmp = 0;
   int n_bad = 0;
   int hit_seen = 0;
   int act_seen = 0;

   player_bullet dut (
      .clk_i(clk_i), .reset_i(reset_i), .frame_i(frame_i), .fire_i(fire_i),
      .player_left_i(player_left_i), .player_top_i(player_top_i),
      .enemy_left_i(enemy_left_i), .enemy_right_i(enemy_right_i),
      .enemy_top_i(enemy_top_i), .enemy_bot_i(enemy_bot_i),
      .enemy_dead_i(enemy_dead_i), .hit_o(hit_o), .active_o(active_o),
      .left_pos_o(left_pos_o), .right_pos_o(right_pos_o),
      .top_pos_o(top_pos_o), .bot_pos_o(bot_pos_o),
      .bullet_red_o(bullet_red_o), .bullet_green_o(bullet_green_o),
      .bullet_blue_o(bullet_blue_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      if (hit_o) hit_seen++;
      if (active_o) act_seen++;
   endtask

   task automatic do_reset(input logic f);
      reset_i = 1'b1;
      fire_i  = f;
      frame_i = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic launch();
      fire_i = 1'b0;
      tick();
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         frame_i = 1'b1;
         tick();
         frame_i = 1'b0;
         tick();
      end
   endtask

   initial begin
      // reset state
      do_reset(1'b0);
      chk("rst_active", active_o, 0);
      chk("rst_hit", hit_o, 0);
      chk("rst_left", left_pos_o, 0);
      chk("rst_top", top_pos_o, 0);
      chk("colour", {bullet_red_o, bullet_green_o, bullet_blue_o}, 12'hF00);

      // launch
      player_left_i = 10'd300;
      player_top_i  = 10'd440;
      launch();
      chk("launch_active", active_o, 1);
      chk("launch_left", left_pos_o, 319);
      chk("launch_right", right_pos_o, 320);
      chk("launch_top", top_pos_o, 432);
      chk("launch_bot", bot_pos_o, 439);

      // flight and miss against a dead enemy
      enemy_dead_i = 1'b1;
      hit_seen = 0;
      frames(108);
      chk("miss_top0", top_pos_o, 0);
      chk("miss_active_before", active_o, 1);
      frames(1);
      chk("miss_active_after", active_o, 0);
      chk("miss_no_hit", hit_seen, 0);

      // launch boundaries: saturation and height limit
      do_reset(1'b0);
      player_left_i = 10'd1000;
      player_top_i  = 10'd8;
      launch();
      chk("sat_left", left_pos_o, 638);
      chk("sat_top0", top_pos_o, 0);
      chk("sat_active", active_o, 1);
      do_reset(1'b0);
      player_left_i = 10'd300;
      player_top_i  = 10'd5;
      launch();
      chk("low_drop", active_o, 0);

      // hit: first overlap at top 108 after 81 frames
      do_reset(1'b0);
      enemy_left_i  = 10'd300;
      enemy_right_i = 10'd340;
      enemy_top_i   = 10'd100;
      enemy_bot_i   = 10'd110;
      enemy_dead_i  = 1'b0;
      player_left_i = 10'd300;
      player_top_i  = 10'd440;
      launch();
      frames(80);
      chk("pre_hit_top", top_pos_o, 112);
      chk("pre_hit_hit", hit_o, 0);
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      chk("ovl_top", top_pos_o, 108);
      chk("ovl_active", active_o, 1);
      chk("ovl_hit", hit_o, 0);
      tick();
      chk("hit_pulse", hit_o, 1);
      chk("hit_active", active_o, 0);
      chk("hit_top_frozen", top_pos_o, 108);
      tick();
      chk("hit_end", hit_o, 0);
      chk("post_hit_active", active_o, 0);
`ifdef PLAYER_BULLET_COOLDOWN_EN
      frames(9);
      frame_i = 1'b1;
      fire_i  = 1'b1;
      tick();
      frame_i = 1'b0;
      fire_i  = 1'b0;
      tick();
      chk("cool_press10", active_o, 0);
      frames(4);
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      chk("cool_press14", active_o, 0);
      frames(1);
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      chk("cool_relaunch", active_o, 1);
`else
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      chk("refire_after_hit", active_o, 1);
      chk("refire_top", top_pos_o, 432);
`endif

      // fire held across reset and a full flight never launches
      enemy_dead_i = 1'b1;
      do_reset(1'b1);
      act_seen = 0;
      frames(150);
      chk("held_no_launch", act_seen, 0);
      fire_i = 1'b0;
      tick();
      fire_i = 1'b1;
      tick();
      chk("held_relaunch", active_o, 1);
      fire_i = 1'b0;

      // fire during flight ignored, then reset mid-flight
      do_reset(1'b0);
      launch();
      frames(58);
      chk("mid_top", top_pos_o, 200);
      fire_i = 1'b1;
      tick();
      fire_i = 1'b0;
      chk("fly_fire_ign", top_pos_o, 200);
      reset_i = 1'b1;
      tick();
      chk("mid_rst_active", active_o, 0);
      chk("mid_rst_hit", hit_o, 0);
      chk("mid_rst_left", left_pos_o, 0);
      chk("mid_rst_top", top_pos_o, 0);
      reset_i = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
